// File: rtl/video_rect_fill_pkg.sv
// Register map, control/status bit positions and FSM states shared by video_rect_fill.
package video_rect_fill_pkg;

    localparam int unsigned COORD_W = 10;

    localparam logic [4:0] REG_P0     = 5'd0;
    localparam logic [4:0] REG_P1     = 5'd1;
    localparam logic [4:0] REG_COLOR  = 5'd2;
    localparam logic [4:0] REG_CTRL   = 5'd3;
    localparam logic [4:0] REG_STATUS = 5'd4;

    localparam int unsigned P_X_LSB = 0;
    localparam int unsigned P_Y_LSB = 16;

    localparam int unsigned CTRL_START = 0;
    localparam int unsigned CTRL_ABORT = 1;

    localparam int unsigned STATUS_BUSY  = 0;
    localparam int unsigned STATUS_DONE  = 1;
    localparam int unsigned STATUS_ERROR = 2;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StFill
    } state_e;

endpackage

// File: rtl/video_rect_fill.sv
// Rectangle fill engine: FPro slot registers feed a scan-order pixel writer into the frame buffer.
// Define RECT_FILL_CLIP_EN to clamp the far corner to the screen instead of rejecting it.
module video_rect_fill
    import video_rect_fill_pkg::*;
#(
    parameter int unsigned H_SIZE = 640,
    parameter int unsigned V_SIZE = 480,
    parameter int unsigned DATA_W = 9,
    parameter int unsigned ADDR_W = 19
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cs,
    input  logic              write,
    input  logic              read,
    input  logic [4:0]        addr,
    input  logic [31:0]       wr_data,
    output logic [31:0]       rd_data,
    output logic              fb_wr,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [DATA_W-1:0] fb_wr_data,
    input  logic              fb_ready
);

    localparam logic [COORD_W-1:0] X_MAX    = COORD_W'(H_SIZE - 1);
    localparam logic [COORD_W-1:0] Y_MAX    = COORD_W'(V_SIZE - 1);
    localparam logic [ADDR_W-1:0]  ROW_STEP = ADDR_W'(H_SIZE);

    // y * H_SIZE as a sum of constant shifts; folds to a few adders.
    function automatic logic [ADDR_W-1:0] times_h(input logic [COORD_W-1:0] y);
        logic [ADDR_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < 32; i++) begin
            if (H_SIZE[i]) acc = acc + (ADDR_W'(y) << i);
        end
        return acc;
    endfunction

    state_e state_q, state_d;

    logic [COORD_W-1:0] x0_q, y0_q, x1_q, y1_q;
    logic [DATA_W-1:0]  color_q;

    logic [COORD_W-1:0] ax0_q, ay0_q, ax1_q, ay1_q;
    logic [COORD_W-1:0] ax0_d, ay0_d, ax1_d, ay1_d;
    logic [DATA_W-1:0]  acolor_q, acolor_d;

    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic [ADDR_W-1:0]  row_base_q, row_base_d;
    logic               done_q, done_d, error_q, error_d;

    logic               reg_wr, ctrl_wr, start_cmd, abort_cmd, busy;
    logic               setup_err;
    logic [COORD_W-1:0] x1_lim, y1_lim;
    logic               unused_bits;

    assign unused_bits = ^{read, wr_data[31:26], wr_data[15:10]};

    assign reg_wr    = cs && write;
    assign ctrl_wr   = reg_wr && (addr == REG_CTRL);
    assign abort_cmd = ctrl_wr && wr_data[CTRL_ABORT];
    assign start_cmd = ctrl_wr && wr_data[CTRL_START] && !wr_data[CTRL_ABORT];
    assign busy      = (state_q != StIdle);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x0_q    <= '0;
            y0_q    <= '0;
            x1_q    <= '0;
            y1_q    <= '0;
            color_q <= '0;
        end else if (reg_wr) begin
            case (addr)
                REG_P0: begin
                    x0_q <= wr_data[P_X_LSB +: COORD_W];
                    y0_q <= wr_data[P_Y_LSB +: COORD_W];
                end
                REG_P1: begin
                    x1_q <= wr_data[P_X_LSB +: COORD_W];
                    y1_q <= wr_data[P_Y_LSB +: COORD_W];
                end
                REG_COLOR: color_q <= wr_data[DATA_W-1:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_data = '0;
        case (addr)
            REG_P0: begin
                rd_data[P_X_LSB +: COORD_W] = x0_q;
                rd_data[P_Y_LSB +: COORD_W] = y0_q;
            end
            REG_P1: begin
                rd_data[P_X_LSB +: COORD_W] = x1_q;
                rd_data[P_Y_LSB +: COORD_W] = y1_q;
            end
            REG_COLOR: rd_data[DATA_W-1:0] = color_q;
            REG_STATUS: begin
                rd_data[STATUS_BUSY]  = busy;
                rd_data[STATUS_DONE]  = done_q;
                rd_data[STATUS_ERROR] = error_q;
            end
            default: ;
        endcase
    end

    // x0<=x1 has already been required, so the far corner bounds the whole rectangle.
    always_comb begin
        setup_err = (ax0_q > ax1_q) || (ay0_q > ay1_q);
`ifdef RECT_FILL_CLIP_EN
        setup_err = setup_err || (ax0_q > X_MAX) || (ay0_q > Y_MAX);
        x1_lim    = (ax1_q > X_MAX) ? X_MAX : ax1_q;
        y1_lim    = (ay1_q > Y_MAX) ? Y_MAX : ay1_q;
`else
        setup_err = setup_err || (ax1_q > X_MAX) || (ay1_q > Y_MAX);
        x1_lim    = ax1_q;
        y1_lim    = ay1_q;
`endif
    end

    always_comb begin
        state_d    = state_q;
        ax0_d      = ax0_q;
        ay0_d      = ay0_q;
        ax1_d      = ax1_q;
        ay1_d      = ay1_q;
        acolor_d   = acolor_q;
        x_d        = x_q;
        y_d        = y_q;
        row_base_d = row_base_q;
        done_d     = done_q;
        error_d    = error_q;

        case (state_q)
            StIdle: begin
                if (start_cmd) begin
                    done_d   = 1'b0;
                    error_d  = 1'b0;
                    ax0_d    = x0_q;
                    ay0_d    = y0_q;
                    ax1_d    = x1_q;
                    ay1_d    = y1_q;
                    acolor_d = color_q;
                    state_d  = StSetup;
                end
            end
            StSetup: begin
                if (abort_cmd) begin
                    state_d = StIdle;
                end else if (setup_err) begin
                    error_d = 1'b1;
                    state_d = StIdle;
                end else begin
                    ax1_d      = x1_lim;
                    ay1_d      = y1_lim;
                    row_base_d = times_h(ay0_q);
                    x_d        = ax0_q;
                    y_d        = ay0_q;
                    state_d    = StFill;
                end
            end
            StFill: begin
                if (abort_cmd) begin
                    state_d = StIdle;
                end else if (fb_ready) begin
                    if (x_q < ax1_q) begin
                        x_d = x_q + 1'b1;
                    end else if (y_q < ay1_q) begin
                        x_d        = ax0_q;
                        y_d        = y_q + 1'b1;
                        row_base_d = row_base_q + ROW_STEP;
                    end else begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        fb_wr      = (state_q == StFill);
        fb_addr    = fb_wr ? (row_base_q + ADDR_W'(x_q)) : '0;
        fb_wr_data = fb_wr ? acolor_q : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            ax0_q      <= '0;
            ay0_q      <= '0;
            ax1_q      <= '0;
            ay1_q      <= '0;
            acolor_q   <= '0;
            x_q        <= '0;
            y_q        <= '0;
            row_base_q <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ax0_q      <= ax0_d;
            ay0_q      <= ay0_d;
            ax1_q      <= ax1_d;
            ay1_q      <= ay1_d;
            acolor_q   <= acolor_d;
            x_q        <= x_d;
            y_q        <= y_d;
            row_base_q <= row_base_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

endmodule
